// File: rtl/mod_exp_sqr_mul_ctrl.sv
// rtl/mod_exp_sqr_mul_ctrl.sv - left-to-right square-and-multiply modexp sequencer driving an external modular multiplier
// Optional: define MOD_EXP_OP_COUNT_EN to add the mm_ops multiply counter output.
module mod_exp_sqr_mul_ctrl #(
  parameter int NBITS = 4096,
  parameter int EBITS = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             done_irq_p,
  output logic             mm_enable_p,
  output logic [NBITS-1:0] mm_a,
  output logic [NBITS-1:0] mm_b,
  output logic [NBITS-1:0] mm_m,
  input  logic [NBITS-1:0] mm_y,
  input  logic             mm_done_irq_p
`ifdef MOD_EXP_OP_COUNT_EN
  ,
  output logic [31:0]      mm_ops
`endif
);

  localparam int CW = $clog2(EBITS + 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, FIN
  } state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] acc, acc_nxt;
  logic [NBITS-1:0] base_r;
  logic [NBITS-1:0] m_r;
  logic [EBITS-1:0] exp_r;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             shift;
  logic             last_bit;

  assign accept   = (state == IDLE) && start_p;
  // The bit being consumed this cycle is the final one when the counter sits at 1.
  assign last_bit = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    shift     = 1'b0;
    case (state)
      IDLE: if (start_p) state_nxt = SCAN;
      SCAN: begin
        shift = 1'b1;
        if (exp_r[EBITS-1]) begin
          // Leading one seeds the accumulator without a multiply.
          acc_nxt   = base_r;
          state_nxt = last_bit ? FIN : SQR_ISSUE;
        end else if (last_bit) begin
          acc_nxt   = {{(NBITS-1){1'b0}}, 1'b1};
          state_nxt = FIN;
        end
      end
      SQR_ISSUE: state_nxt = SQR_WAIT;
      SQR_WAIT: begin
        if (mm_done_irq_p) begin
          acc_nxt = mm_y;
          if (exp_r[EBITS-1]) begin
            state_nxt = MUL_ISSUE;
          end else begin
            shift     = 1'b1;
            state_nxt = last_bit ? FIN : SQR_ISSUE;
          end
        end
      end
      MUL_ISSUE: state_nxt = MUL_WAIT;
      MUL_WAIT: begin
        if (mm_done_irq_p) begin
          acc_nxt   = mm_y;
          shift     = 1'b1;
          state_nxt = last_bit ? FIN : SQR_ISSUE;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE) && (state != FIN);
    done_irq_p  = (state == FIN);
    mm_enable_p = (state == SQR_ISSUE) || (state == MUL_ISSUE);
  end

  // Operands are loaded on entry to an issue state so they stay frozen through the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      base_r <= '0;
      m_r    <= '0;
      exp_r  <= '0;
      cnt    <= '0;
      result <= '0;
      mm_a   <= '0;
      mm_b   <= '0;
      mm_m   <= '0;
    end else begin
      acc <= acc_nxt;
      if (accept) begin
        base_r <= base;
        exp_r  <= exp;
        m_r    <= m;
        cnt    <= CW'(EBITS);
      end else if (shift) begin
        exp_r <= exp_r << 1;
        cnt   <= cnt - CW'(1);
      end
      if (state_nxt == SQR_ISSUE && state != SQR_ISSUE) begin
        mm_a <= acc_nxt;
        mm_b <= acc_nxt;
        mm_m <= m_r;
      end
      if (state_nxt == MUL_ISSUE && state != MUL_ISSUE) begin
        mm_a <= acc_nxt;
        mm_b <= base_r;
        mm_m <= m_r;
      end
      if (state_nxt == FIN && state != FIN) result <= acc_nxt;
    end
  end

`ifdef MOD_EXP_OP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                  mm_ops <= '0;
    else if (accept)                          mm_ops <= '0;
    else if (mm_enable_p && (mm_ops != '1))   mm_ops <= mm_ops + 32'd1;
  end
`endif

endmodule
